// File: rtl/cpu31_pkg.sv
// cpu31_pkg: shared definitions for the multi-cycle CPU controller.
//   - opcode / funct constants for the 31 supported instructions
//   - ALU opcode encoding (shared with the ALU)
//   - FSM state encoding, mux-select encodings
//   - decoded control bundle carried from ID into EX/MEM/WB
package cpu31_pkg;

    // FSM states
    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_EX   = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_WB   = 3'b100;
    localparam logic [2:0] S_HALT = 3'b101;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDU = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_LUI  = 4'b1101;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Mux selects
    localparam logic [1:0] B_RT    = 2'd0;
    localparam logic [1:0] B_SEXT  = 2'd1;
    localparam logic [1:0] B_ZEXT  = 2'd2;
    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JMP  = 2'd2;
    localparam logic [1:0] PC_RS   = 2'd3;
    localparam logic [1:0] WA_RD   = 2'd0;
    localparam logic [1:0] WA_RT   = 2'd1;
    localparam logic [1:0] WA_R31  = 2'd2;
    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_MEM  = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;

    // Instruction class: selects the EX/MEM/WB path through the FSM
    typedef enum logic [2:0] {
        K_ALU = 3'd0,
        K_LW  = 3'd1,
        K_SW  = 3'd2,
        K_BEQ = 3'd3,
        K_BNE = 3'd4,
        K_J   = 3'd5,
        K_JR  = 3'd6,
        K_JAL = 3'd7
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [3:0] aluc;
        logic       a_sel;
        logic [1:0] b_sel;
        logic [1:0] waddr_sel;
        logic [1:0] wdata_sel;
        logic       ovf_en;     // overflow suppresses the write-back
    } ctrl_t;

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode: combinational instruction decoder.
//   instr   in  32  instruction word
//   ctrl    out     decoded control bundle (ctrl_t)
//   illegal out 1   opcode/funct not in the supported set
module cpu_decode
    import cpu31_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    // register/immediate fields are consumed by the datapath, not here
    assign unused_fields = ^instr[25:6];

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.waddr_sel = WA_RD;
                ctrl.wdata_sel = WD_ALU;
                case (fn)
                    FN_ADD:  begin ctrl.aluc = ALU_ADD; ctrl.ovf_en = 1'b1; end
                    FN_ADDU: ctrl.aluc = ALU_ADDU;
                    FN_SUB:  begin ctrl.aluc = ALU_SUB; ctrl.ovf_en = 1'b1; end
                    FN_SUBU: ctrl.aluc = ALU_SUBU;
                    FN_AND:  ctrl.aluc = ALU_AND;
                    FN_OR:   ctrl.aluc = ALU_OR;
                    FN_XOR:  ctrl.aluc = ALU_XOR;
                    FN_NOR:  ctrl.aluc = ALU_NOR;
                    FN_SLT:  ctrl.aluc = ALU_SLT;
                    FN_SLTU: ctrl.aluc = ALU_SLTU;
                    FN_SLL:  begin ctrl.aluc = ALU_SLL; ctrl.a_sel = 1'b1; end
                    FN_SRL:  begin ctrl.aluc = ALU_SRL; ctrl.a_sel = 1'b1; end
                    FN_SRA:  begin ctrl.aluc = ALU_SRA; ctrl.a_sel = 1'b1; end
                    FN_SLLV: ctrl.aluc = ALU_SLL;
                    FN_SRLV: ctrl.aluc = ALU_SRL;
                    FN_SRAV: ctrl.aluc = ALU_SRA;
                    FN_JR:   ctrl.kind = K_JR;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin ctrl.aluc = ALU_ADD;  ctrl.b_sel = B_SEXT; ctrl.ovf_en = 1'b1;
                            ctrl.waddr_sel = WA_RT; end
            OP_ADDIU: begin ctrl.aluc = ALU_ADDU; ctrl.b_sel = B_SEXT; ctrl.waddr_sel = WA_RT; end
            OP_SLTI:  begin ctrl.aluc = ALU_SLT;  ctrl.b_sel = B_SEXT; ctrl.waddr_sel = WA_RT; end
            OP_SLTIU: begin ctrl.aluc = ALU_SLTU; ctrl.b_sel = B_SEXT; ctrl.waddr_sel = WA_RT; end
            OP_ANDI:  begin ctrl.aluc = ALU_AND;  ctrl.b_sel = B_ZEXT; ctrl.waddr_sel = WA_RT; end
            OP_ORI:   begin ctrl.aluc = ALU_OR;   ctrl.b_sel = B_ZEXT; ctrl.waddr_sel = WA_RT; end
            OP_XORI:  begin ctrl.aluc = ALU_XOR;  ctrl.b_sel = B_ZEXT; ctrl.waddr_sel = WA_RT; end
            OP_LUI:   begin ctrl.aluc = ALU_LUI;  ctrl.b_sel = B_ZEXT; ctrl.waddr_sel = WA_RT; end
            OP_LW: begin
                ctrl.kind      = K_LW;
                ctrl.aluc      = ALU_ADD;
                ctrl.b_sel     = B_SEXT;
                ctrl.waddr_sel = WA_RT;
                ctrl.wdata_sel = WD_MEM;
            end
            OP_SW:  begin ctrl.kind = K_SW; ctrl.aluc = ALU_ADD; ctrl.b_sel = B_SEXT; end
            OP_BEQ: begin ctrl.kind = K_BEQ; ctrl.aluc = ALU_SUB; end
            OP_BNE: begin ctrl.kind = K_BNE; ctrl.aluc = ALU_SUB; end
            OP_J:   ctrl.kind = K_J;
            OP_JAL: begin
                ctrl.kind      = K_JAL;
                ctrl.waddr_sel = WA_R31;
                ctrl.wdata_sel = WD_PC4;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle controller (IF/ID/EX/MEM/WB/HALT).
//   clk, rst (sync, active-high)
//   instr, instr_valid         instruction fetch handshake
//   zero, overflow             ALU flags, sampled in EX
//   aluc, alu_a_sel, alu_b_sel ALU controls (EX only)
//   ir_we, pc_we, pc_src       fetch / PC update
//   dmem_re, dmem_we           data memory strobes (MEM only)
//   rf_we, rf_waddr_sel, rf_wdata_sel  register write-back (WB only)
//   state                      current state, debug
//   illegal                    sticky unsupported-instruction flag
module cpu_ctrl_fsm
    import cpu31_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        zero,
    input  logic        overflow,
    output logic [3:0]  aluc,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        rf_we,
    output logic [1:0]  rf_waddr_sel,
    output logic [1:0]  rf_wdata_sel,
    output logic [2:0]  state,
    output logic        illegal
);

    logic [31:0] ir_q;
    ctrl_t       ctrl_q;
    ctrl_t       dec_ctrl;
    logic        dec_illegal;
    logic        ovf_q;
    logic        illegal_q;

    cpu_decode u_dec (
        .instr   (ir_q),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IF;
            ir_q      <= '0;
            ctrl_q    <= '0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_IF: if (instr_valid) begin
                    ir_q  <= instr;
                    state <= S_ID;
                end
                S_ID: begin
                    ctrl_q <= dec_ctrl;
                    if (dec_illegal) begin
                        illegal_q <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        state <= S_EX;
                    end
                end
                S_EX: begin
                    ovf_q <= overflow & ctrl_q.ovf_en;
                    case (ctrl_q.kind)
                        K_LW, K_SW:              state <= S_MEM;
                        K_BEQ, K_BNE, K_J, K_JR: state <= S_IF;
                        default:                 state <= S_WB;  // ALU ops, jal
                    endcase
                end
                S_MEM:  state <= (ctrl_q.kind == K_LW) ? S_WB : S_IF;
                S_WB:   state <= S_IF;
                S_HALT: state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

    assign illegal = illegal_q;

    // Outputs are decoded from state; forcing them low while rst is high
    // keeps a reset that lands mid-instruction from leaking a strobe.
    always_comb begin
        aluc         = '0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = '0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_INC;
        dmem_re      = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        rf_waddr_sel = '0;
        rf_wdata_sel = '0;
        if (!rst) begin
            case (state)
                S_IF: if (instr_valid) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
                S_EX: begin
                    aluc      = ctrl_q.aluc;
                    alu_a_sel = ctrl_q.a_sel;
                    alu_b_sel = ctrl_q.b_sel;
                    case (ctrl_q.kind)
                        K_BEQ: if (zero)  begin pc_we = 1'b1; pc_src = PC_BR; end
                        K_BNE: if (!zero) begin pc_we = 1'b1; pc_src = PC_BR; end
                        K_J, K_JAL: begin pc_we = 1'b1; pc_src = PC_JMP; end
                        K_JR:       begin pc_we = 1'b1; pc_src = PC_RS;  end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (ctrl_q.kind == K_LW) dmem_re = 1'b1;
                    else                     dmem_we = 1'b1;
                end
                S_WB: begin
                    rf_we        = ~ovf_q;
                    rf_waddr_sel = ctrl_q.waddr_sel;
                    rf_wdata_sel = ctrl_q.wdata_sel;
                end
                default: ;
            endcase
        end
    end

endmodule
